regfile_write_arbiter: RTL and testbench

- Shares the single register-file write port (RegWrite / write_reg / write_data) between NUM_REQ writeback sources, e.g. ALU result, load data and debug/test injector.
- Round-robin arbitration with a valid/ready handshake per requester.
- Output port is registered, so it feeds the register file's write inputs directly.
- Drops writes whose address is outside the implemented register range and flags them.

---
 rtl/regfile_write_arbiter_pkg.sv | 12 +
 rtl/regfile_write_arbiter_if.sv | 25 ++
 rtl/regfile_write_arbiter_rr_arbiter.sv | 26 ++
 rtl/regfile_write_arbiter.sv | 74 +++++++
 tb/tb_regfile_write_arbiter.sv | 139 +++++++++++++
 5 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// regfile_pkg: shared register-file widths and the write-request record.
package regfile_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int REG_COUNT = 8;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;
    typedef struct packed {
        reg_addr_t addr;
        reg_data_t data;
    } regwr_req_t;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: requester-side handshake and register-file write port bundle.
interface regfile_write_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic                      hold;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      RegWrite;
    logic [ADDR_W-1:0]         write_reg;
    logic [DATA_W-1:0]         write_data;
    logic                      addr_err;
    logic                      busy;
    modport master (
        output hold, req_valid, req_addr, req_data,
        input  req_ready, RegWrite, write_reg, write_data, addr_err, busy
    );
    modport slave (
        input  hold, req_valid, req_addr, req_data,
        output req_ready, RegWrite, write_reg, write_data, addr_err, busy
    );
endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// rr_arbiter: combinational rotating-priority one-hot grant starting at ptr.
module rr_arbiter #(
    parameter int N = 3,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          enable,
    output logic [N-1:0]  gnt
);
    logic [PW:0] idx;
    logic        found;
    always_comb begin
        gnt = '0;
        found = 1'b0;
        idx = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr} + (PW+1)'(k);
            idx = (idx >= (PW+1)'(N)) ? idx - (PW+1)'(N) : idx;
            if (enable && !found && req[idx[PW-1:0]]) begin
                gnt[idx[PW-1:0]] = 1'b1;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin sharing of the register-file write port with registered output.
// REGWR_ARB_FIXED_PRIO_EN gives requester 0 absolute priority; the rest rotate among 1..NUM_REQ-1.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int NUM_REGS = REG_COUNT,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
) (
    input logic clk,
    input logic rst_n,
    regfile_write_arbiter_if.slave bus
);
    localparam int PW = $clog2(NUM_REQ);
    logic [PW-1:0]      ptr, sel, ptr_nxt;
    logic [NUM_REQ-1:0] rr_req, rr_gnt, gnt;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic               en, xfer, in_range, adv;
    logic               reg_we, reg_err;
    logic [ADDR_W-1:0]  reg_addr;
    logic [DATA_W-1:0]  reg_data;
    assign en = rst_n && !bus.hold;
`ifdef REGWR_ARB_FIXED_PRIO_EN
    localparam logic [PW-1:0] PTR_RST = PW'(1);
    assign rr_req = {bus.req_valid[NUM_REQ-1:1], 1'b0};
    assign gnt = (en && bus.req_valid[0]) ? NUM_REQ'(1) : rr_gnt;
    assign adv = xfer && (sel != '0);
`else
    localparam logic [PW-1:0] PTR_RST = '0;
    assign rr_req = bus.req_valid;
    assign gnt = rr_gnt;
    assign adv = xfer;
`endif
    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req(rr_req),
        .ptr(ptr),
        .enable(en),
        .gnt(rr_gnt)
    );
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_REQ; i++) sel = gnt[i] ? PW'(i) : sel;
    end
    assign xfer = |gnt;
    assign sel_addr = bus.req_addr[sel*ADDR_W +: ADDR_W];
    assign sel_data = bus.req_data[sel*DATA_W +: DATA_W];
    assign in_range = {1'b0, sel_addr} < (ADDR_W+1)'(NUM_REGS);
    assign ptr_nxt = (sel == PW'(NUM_REQ-1)) ? PTR_RST : sel + 1'b1;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= PTR_RST;
            reg_we <= 1'b0;
            reg_err <= 1'b0;
            reg_addr <= '0;
            reg_data <= '0;
        end else begin
            reg_we <= xfer && in_range;
            reg_err <= xfer && !in_range;
            if (adv) ptr <= ptr_nxt;
            if (xfer && in_range) begin
                reg_addr <= sel_addr;
                reg_data <= sel_data;
            end
        end
    end
    assign bus.req_ready = gnt;
    assign bus.RegWrite = reg_we;
    assign bus.write_reg = reg_addr;
    assign bus.write_data = reg_data;
    assign bus.addr_err = reg_err;
    assign bus.busy = (|bus.req_valid) || reg_we;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed stimulus with a due-cycle scoreboard on the write port.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;
    typedef struct {
        int         due;
        bit         we;
        regwr_req_t w;
    } exp_t;
    logic clk = 0, rst_n = 0;
    int cyc = 0, checks = 0, errors = 0;
    bit started = 0;
    exp_t q[$];
    reg_addr_t addr_arr[3];
    reg_data_t data_arr[3];
    reg_addr_t m_reg = '0;
    reg_data_t m_data = '0;
    regfile_write_arbiter_if #(.NUM_REQ(3), .ADDR_W(5), .DATA_W(32)) bus ();
    regfile_write_arbiter #(.NUM_REQ(3), .NUM_REGS(8), .ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );
    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h (cycle %0d)", n, a, e, cyc);
        end
    endtask
    task automatic push(input int i);
        exp_t e;
        e.due = cyc + 1;
        e.we = addr_arr[i] < 5'd8;
        if (e.we) begin
            m_reg = addr_arr[i];
            m_data = data_arr[i];
        end
        e.w.addr = m_reg;
        e.w.data = m_data;
        q.push_back(e);
    endtask
    task automatic step(input logic r, input logic h, input logic [2:0] v, input logic [2:0] g);
        @(posedge clk);
        #1;
        rst_n = r;
        bus.hold = h;
        bus.req_valid = v;
        for (int i = 0; i < 3; i++) begin
            bus.req_addr[i*5 +: 5] = addr_arr[i];
            bus.req_data[i*32 +: 32] = data_arr[i];
        end
        @(negedge clk);
        chk("req_ready", 64'(bus.req_ready), 64'(g));
        if (!r) begin
            m_reg = '0;
            m_data = '0;
        end
        for (int i = 0; i < 3; i++) if (g[i] && r) push(i);
    endtask
    always @(negedge clk) begin
        if (started) begin
            if (q.size() != 0 && q[0].due == cyc) begin
                exp_t e;
                e = q.pop_front();
                chk("wr_port", {26'd0, bus.RegWrite, bus.addr_err, bus.write_reg, bus.write_data},
                    {26'd0, e.we, !e.we, e.w.addr, e.w.data});
            end else if (bus.RegWrite || bus.addr_err) begin
                chk("unexpected_out", {62'd0, bus.RegWrite, bus.addr_err}, 64'd0);
            end
        end
    end
    initial begin
        bus.hold = 0;
        bus.req_valid = 3'b111;
        bus.req_addr = '0;
        bus.req_data = '0;
        for (int i = 0; i < 3; i++) begin
            addr_arr[i] = reg_addr_t'(i + 1);
            data_arr[i] = 32'hA0 + i;
        end
        @(posedge clk);
        started = 1;
        step(0, 0, 3'b111, 3'b000);
        step(0, 0, 3'b111, 3'b000);
        chk("rst_regwrite", 64'(bus.RegWrite), 64'd0);
        chk("rst_addr_err", 64'(bus.addr_err), 64'd0);
        chk("rst_write_reg", 64'(bus.write_reg), 64'd0);
        chk("rst_write_data", 64'(bus.write_data), 64'd0);
`ifdef REGWR_ARB_FIXED_PRIO_EN
        repeat (4) step(1, 0, 3'b111, 3'b001);
        step(1, 0, 3'b110, 3'b010);
        step(1, 0, 3'b110, 3'b100);
        step(1, 0, 3'b110, 3'b010);
        step(1, 0, 3'b110, 3'b100);
        step(1, 0, 3'b000, 3'b000);
`else
        step(1, 0, 3'b111, 3'b001);
        step(1, 0, 3'b111, 3'b010);
        step(1, 0, 3'b111, 3'b100);
        step(1, 0, 3'b111, 3'b001);
        step(1, 0, 3'b111, 3'b010);
        step(1, 0, 3'b111, 3'b100);
        step(1, 0, 3'b000, 3'b000);
        chk("busy_on_write", 64'(bus.busy), 64'd1);
        step(1, 0, 3'b000, 3'b000);
        chk("busy_idle", 64'(bus.busy), 64'd0);
        addr_arr[1] = 5'd12;
        data_arr[1] = 32'hDEAD;
        step(1, 0, 3'b010, 3'b010);
        addr_arr[0] = 5'd0;
        data_arr[0] = 32'h11;
        addr_arr[2] = 5'd7;
        data_arr[2] = 32'h77;
        repeat (3) step(1, 1, 3'b101, 3'b000);
        chk("busy_hold", 64'(bus.busy), 64'd1);
        step(1, 0, 3'b101, 3'b100);
        step(1, 0, 3'b101, 3'b001);
        addr_arr[0] = 5'd8;
        data_arr[0] = 32'hBAD;
        step(1, 0, 3'b001, 3'b001);
        step(1, 0, 3'b000, 3'b000);
        addr_arr[2] = 5'd3;
        data_arr[2] = 32'h5;
        step(0, 0, 3'b100, 3'b000);
        addr_arr[0] = 5'd2;
        data_arr[0] = 32'h22;
        step(1, 0, 3'b111, 3'b001);
        chk("post_rst_regwrite", 64'(bus.RegWrite), 64'd0);
        step(1, 0, 3'b000, 3'b000);
`endif
        step(1, 0, 3'b000, 3'b000);
        step(1, 0, 3'b000, 3'b000);
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
